// File: rtl/str_pattern_fsm_if.sv
// Character/verdict/config bundle for str_pattern_fsm; slave = checker, master = driver.
interface str_pattern_fsm_if #(
    parameter int N_TOK = 4,
    parameter int CNT_W = 4,
    parameter int N_CLS = 14
);
    localparam int IDX_W = (N_TOK > 1) ? $clog2(N_TOK) : 1;

    logic             valid;
    logic             verify_error;
    logic [N_CLS-1:0] cls;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [N_CLS-1:0] cfg_mask;
    logic [CNT_W-1:0] cfg_min;
    logic [CNT_W-1:0] cfg_max;
    logic             cfg_last;
    logic [2:0]       state;
    logic [IDX_W-1:0] tok_idx;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             match;

    modport slave (
        input  valid, verify_error, cls, cfg_we, cfg_idx, cfg_mask, cfg_min, cfg_max, cfg_last,
        output state, tok_idx, cnt, done, match
    );

    modport master (
        output valid, verify_error, cls, cfg_we, cfg_idx, cfg_mask, cfg_min, cfg_max, cfg_last,
        input  state, tok_idx, cnt, done, match
    );
endinterface

// File: rtl/str_pattern_fsm.sv
// Table-driven string checker: one classified char per valid, one-cycle registered verdict per string.
// Macro STR_PAT_WS_SKIP_EN: in RUN, whitespace not accepted by the current token is skipped.
module str_pattern_fsm #(
    parameter int N_TOK = 4,
    parameter int CNT_W = 4,
    parameter int N_CLS = 14
) (
    input logic              clk,
    input logic              rst,
    str_pattern_fsm_if.slave bus
);
    localparam int IDX_W = (N_TOK > 1) ? $clog2(N_TOK) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_STOP  = 3'd2,
        S_ERROR = 3'd3,
        S_RUN   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] tok_q, tok_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mid_q, mid_d;
    logic             done_q, done_d;
    logic             match_q, match_d;

    logic [N_CLS-1:0] mask_q [N_TOK];
    logic [CNT_W-1:0] min_q  [N_TOK];
    logic [CNT_W-1:0] max_q  [N_TOK];
    logic [N_TOK-1:0] last_q;

    logic [CNT_W-1:0] emin [N_TOK];
    logic [N_TOK-1:0] hit_vec;
    logic [IDX_W-1:0] fin_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic             hit_cur, hit_nxt, is_final, min_ok, ws_skip, sof;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_TOK; i++) begin
                mask_q[i] <= '0;
                min_q[i]  <= CNT_W'(1);
                max_q[i]  <= CNT_W'(1);
            end
            last_q <= '0;
        end else if (bus.cfg_we && state_q == S_IDLE && int'(bus.cfg_idx) < N_TOK) begin
            mask_q[bus.cfg_idx] <= bus.cfg_mask;
            min_q[bus.cfg_idx]  <= bus.cfg_min;
            max_q[bus.cfg_idx]  <= bus.cfg_max;
            last_q[bus.cfg_idx] <= bus.cfg_last;
        end
    end

    // A token whose max is below its effective min never hits, which makes it unmatchable.
    always_comb begin
        fin_idx = IDX_W'(N_TOK - 1);
        for (int i = N_TOK - 1; i >= 0; i--) begin
            if (last_q[i]) fin_idx = IDX_W'(i);
        end
        for (int i = 0; i < N_TOK; i++) begin
            emin[i]    = (min_q[i] == '0) ? CNT_W'(1) : min_q[i];
            hit_vec[i] = (|(bus.cls[N_CLS-1:1] & mask_q[i][N_CLS-1:1])) && (max_q[i] >= emin[i]);
        end
    end

    assign nxt_idx  = (tok_q == IDX_W'(N_TOK - 1)) ? tok_q : tok_q + IDX_W'(1);
    assign hit_cur  = hit_vec[tok_q];
    assign hit_nxt  = hit_vec[nxt_idx];
    assign is_final = (tok_q == fin_idx);
    assign min_ok   = (cnt_q >= emin[tok_q]);
    assign sof      = bus.valid && bus.cls[0];

`ifdef STR_PAT_WS_SKIP_EN
    assign ws_skip = bus.cls[10] && !hit_cur;
`else
    assign ws_skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tok_d   = tok_q;
        cnt_d   = cnt_q;
        mid_d   = mid_q;
        case (state_q)
            S_IDLE: begin
                if (sof && !bus.verify_error) begin
                    state_d = S_START;
                    tok_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (bus.verify_error) begin
                    state_d = S_ERROR;
                    mid_d   = 1'b0;
                end else if (bus.valid) begin
                    if (bus.cls[0]) begin
                        state_d = S_ERROR;
                        mid_d   = 1'b0;
                    end else if (hit_vec[0]) begin
                        state_d = S_RUN;
                        tok_d   = '0;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = S_ERROR;
                        mid_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.verify_error) begin
                    state_d = S_ERROR;
                    mid_d   = 1'b0;
                end else if (bus.valid) begin
                    if (bus.cls[0]) begin
                        state_d = (is_final && min_ok) ? S_STOP : S_ERROR;
                        mid_d   = 1'b0;
                    end else if (ws_skip) begin
                        state_d = S_RUN;
                    end else if (hit_cur && cnt_q < max_q[tok_q]) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (min_ok && !is_final && hit_nxt) begin
                        tok_d = nxt_idx;
                        cnt_d = CNT_W'(1);
                    end else begin
                        state_d = S_ERROR;
                        mid_d   = 1'b1;
                    end
                end
            end
            S_STOP: state_d = S_IDLE;
            // The closing \0 of a rejected string is swallowed here so it cannot restart.
            S_ERROR: begin
                if (!mid_q || sof || bus.verify_error) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        done_d  = (state_d == S_STOP) || (state_d == S_ERROR && state_q != S_ERROR);
        match_d = (state_d == S_STOP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tok_q   <= '0;
            cnt_q   <= '0;
            mid_q   <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tok_q   <= tok_d;
            cnt_q   <= cnt_d;
            mid_q   <= mid_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.tok_idx = tok_q;
    assign bus.cnt     = cnt_q;
    assign bus.done    = done_q;
    assign bus.match   = match_q;
endmodule

// File: tb/tb_str_pattern_fsm.sv
// Self-checking bench for str_pattern_fsm: directed scenarios plus randomized strings vs a string-level model.
module tb_str_pattern_fsm;
    localparam int N_TOK = 4;

    localparam logic [13:0] NUL = 14'h0001;
    localparam logic [13:0] DOL = 14'h0040;
    localparam logic [13:0] CA  = 14'h0814;
    localparam logic [13:0] DIG = 14'h0018;
    localparam logic [13:0] SP  = 14'h0400;
    localparam logic [13:0] SB  = 14'h1012;
    localparam logic [15:0] IDL = 16'h0000;
    localparam logic [15:0] VEP = 16'h8000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests;
    int   fails;

    logic [13:0] m_mask [N_TOK];
    int          m_min  [N_TOK];
    int          m_max  [N_TOK];
    bit          m_last [N_TOK];
    logic [13:0] sq [$];

    str_pattern_fsm_if #(.N_TOK(4), .CNT_W(4), .N_CLS(14)) bus ();

    str_pattern_fsm #(.N_TOK(4), .CNT_W(4), .N_CLS(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] S(input logic [13:0] c);
        return {2'b01, c};
    endfunction

    function automatic logic [10:0] T(input int s, input int t, input int c, input int d, input int m);
        return {3'(s), 2'(t), 4'(c), 1'(d), 1'(m)};
    endfunction

    function automatic logic [10:0] mk(input logic [10:0] e);
        return (e[10:8] == 3'd4) ? 11'h7FF : 11'b111_00_0000_11;
    endfunction

    function automatic logic [10:0] cur();
        return {bus.state, bus.tok_idx, bus.cnt, bus.done, bus.match};
    endfunction

    // String-level reference: walks the token list using the grammar rules directly.
    function automatic int emin(input int t);
        return (m_min[t] == 0) ? 1 : m_min[t];
    endfunction

    function automatic bit hit(input logic [13:0] c, input int t);
        return (|(c[13:1] & m_mask[t][13:1])) && (m_max[t] >= emin(t));
    endfunction

    function automatic bit model_accept();
        int fin = N_TOK - 1;
        int t = 0;
        int cnt = 1;
        logic [13:0] c;
        for (int i = N_TOK - 1; i >= 0; i--) if (m_last[i]) fin = i;
        if (sq.size() == 0) return 1'b0;
        if (!hit(sq[0], 0)) return 1'b0;
        for (int k = 1; k < sq.size(); k++) begin
            c = sq[k];
`ifdef STR_PAT_WS_SKIP_EN
            if (c[10] && !hit(c, t)) continue;
`endif
            if (hit(c, t) && cnt < m_max[t]) cnt++;
            else if (cnt >= emin(t) && t != fin && hit(c, t + 1)) begin
                t++;
                cnt = 1;
            end else return 1'b0;
        end
        return (t == fin) && (cnt >= emin(t));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N_TOK; i++) begin
            m_mask[i] = '0; m_min[i] = 1; m_max[i] = 1; m_last[i] = 1'b0;
        end
    endfunction

    function automatic logic [13:0] rchar();
        int k = $urandom_range(0, 6);
        logic [13:0] c = '0;
        c[(k == 6) ? 10 : k + 1] = 1'b1;
        if ($urandom_range(0, 1) == 1) c[$urandom_range(1, 6)] = 1'b1;
        return c;
    endfunction

    function automatic logic [13:0] rmask();
        logic [6:0] r = 7'($urandom_range(0, 127));
        logic [13:0] m = '0;
        m[6:1] = r[5:0];
        m[10]  = r[6];
        return m;
    endfunction

    task automatic step(input logic [15:0] s);
        bus.verify_error = s[15];
        bus.valid        = s[14];
        bus.cls          = s[13:0];
        @(posedge clk);
        #1;
        bus.verify_error = 1'b0;
        bus.valid        = 1'b0;
    endtask

    task automatic cfg(input int idx, input logic [13:0] mask, input int mn, input int mx, input bit last);
        bus.cfg_we = 1'b1; bus.cfg_idx = 2'(idx); bus.cfg_mask = mask;
        bus.cfg_min = 4'(mn); bus.cfg_max = 4'(mx); bus.cfg_last = last;
        m_mask[idx] = mask; m_min[idx] = mn; m_max[idx] = mx; m_last[idx] = last;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic program_std();
        cfg(0, DOL, 1, 1, 1'b0);
        cfg(1, 14'h000C, 1, 3, 1'b1);
    endtask

    task automatic test_reset();
        logic [15:0] st [4];
        logic [10:0] ex [4];
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (cur() !== 11'h000) begin
            fails++; $display("FAIL reset_outputs got=%h exp=000", cur());
        end
        rst = 1'b1;
        model_clear();
        st = '{S(NUL), S(DOL), S(NUL), IDL};
        ex = '{T(1,0,0,0,0), T(3,0,0,1,0), T(0,0,0,0,0), T(0,0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            step(st[i]);
            tests++;
            if ((cur() & mk(ex[i])) !== (ex[i] & mk(ex[i]))) begin
                fails++; $display("FAIL reset_table[%0d] got=%h exp=%h", i, cur(), ex[i]);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] st [7];
        logic [10:0] ex [7];
        st = '{S(NUL), S(DOL), S(CA), S(DIG), S(DIG), S(NUL), IDL};
        ex = '{T(1,0,0,0,0), T(4,0,1,0,0), T(4,1,1,0,0), T(4,1,2,0,0), T(4,1,3,0,0),
               T(2,0,0,1,1), T(0,0,0,0,0)};
        for (int i = 0; i < 7; i++) begin
            step(st[i]);
            tests++;
            if ((cur() & mk(ex[i])) !== (ex[i] & mk(ex[i]))) begin
                fails++; $display("FAIL basic[%0d] got=%h exp=%h", i, cur(), ex[i]);
            end
        end
    endtask

    task automatic test_too_long();
        logic [15:0] st [10];
        logic [10:0] ex [10];
        st = '{S(NUL), S(DOL), S(CA), S(DIG), S(DIG), S(DIG), IDL, S(CA), S(NUL), IDL};
        ex = '{T(1,0,0,0,0), T(4,0,1,0,0), T(4,1,1,0,0), T(4,1,2,0,0), T(4,1,3,0,0),
               T(3,0,0,1,0), T(3,0,0,0,0), T(3,0,0,0,0), T(0,0,0,0,0), T(0,0,0,0,0)};
        for (int i = 0; i < 10; i++) begin
            step(st[i]);
            tests++;
            if ((cur() & mk(ex[i])) !== (ex[i] & mk(ex[i]))) begin
                fails++; $display("FAIL too_long[%0d] got=%h exp=%h", i, cur(), ex[i]);
            end
        end
    endtask

    task automatic test_empty();
        logic [15:0] st [3];
        logic [10:0] ex [3];
        st = '{S(NUL), S(NUL), IDL};
        ex = '{T(1,0,0,0,0), T(3,0,0,1,0), T(0,0,0,0,0)};
        for (int i = 0; i < 3; i++) begin
            step(st[i]);
            tests++;
            if ((cur() & mk(ex[i])) !== (ex[i] & mk(ex[i]))) begin
                fails++; $display("FAIL empty[%0d] got=%h exp=%h", i, cur(), ex[i]);
            end
        end
    endtask

    task automatic test_verify_error();
        logic [15:0] st [6];
        logic [10:0] ex [6];
        st = '{S(NUL), S(DOL), VEP, IDL, VEP | S(NUL), IDL};
        ex = '{T(1,0,0,0,0), T(4,0,1,0,0), T(3,0,0,1,0), T(0,0,0,0,0), T(0,0,0,0,0), T(0,0,0,0,0)};
        for (int i = 0; i < 6; i++) begin
            step(st[i]);
            tests++;
            if ((cur() & mk(ex[i])) !== (ex[i] & mk(ex[i]))) begin
                fails++; $display("FAIL verify_error[%0d] got=%h exp=%h", i, cur(), ex[i]);
            end
        end
    endtask

    task automatic test_cfg_ignored();
        logic [15:0] st [11];
        logic [10:0] ex [11];
        st = '{S(NUL), S(DOL), IDL, S(CA), S(NUL), IDL, S(NUL), S(DOL), S(CA), S(NUL), IDL};
        ex = '{T(1,0,0,0,0), T(4,0,1,0,0), T(4,0,1,0,0), T(4,1,1,0,0), T(2,0,0,1,1), T(0,0,0,0,0),
               T(1,0,0,0,0), T(4,0,1,0,0), T(4,1,1,0,0), T(2,0,0,1,1), T(0,0,0,0,0)};
        for (int i = 0; i < 11; i++) begin
            if (i == 2) begin
                bus.cfg_we = 1'b1; bus.cfg_idx = 2'd0; bus.cfg_mask = 14'h0002;
                bus.cfg_min = 4'd1; bus.cfg_max = 4'd1; bus.cfg_last = 1'b0;
            end
            step(st[i]);
            bus.cfg_we = 1'b0;
            tests++;
            if ((cur() & mk(ex[i])) !== (ex[i] & mk(ex[i]))) begin
                fails++; $display("FAIL cfg_ignored[%0d] got=%h exp=%h", i, cur(), ex[i]);
            end
        end
    endtask

    task automatic test_cfg_on_start();
        logic [15:0] st [5];
        logic [10:0] ex [5];
        st = '{S(NUL), S(SB), S(CA), S(NUL), IDL};
        ex = '{T(1,0,0,0,0), T(4,0,1,0,0), T(4,1,1,0,0), T(2,0,0,1,1), T(0,0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                bus.cfg_we = 1'b1; bus.cfg_idx = 2'd0; bus.cfg_mask = 14'h0002;
                bus.cfg_min = 4'd1; bus.cfg_max = 4'd1; bus.cfg_last = 1'b0;
                m_mask[0] = 14'h0002;
            end
            step(st[i]);
            bus.cfg_we = 1'b0;
            tests++;
            if ((cur() & mk(ex[i])) !== (ex[i] & mk(ex[i]))) begin
                fails++; $display("FAIL cfg_on_start[%0d] got=%h exp=%h", i, cur(), ex[i]);
            end
        end
        cfg(0, DOL, 1, 1, 1'b0);
    endtask

    task automatic test_ws();
        logic [15:0] st [7];
        logic [10:0] ex [7];
        st = '{S(NUL), S(DOL), S(CA), S(SP), S(DIG), S(NUL), IDL};
`ifdef STR_PAT_WS_SKIP_EN
        ex = '{T(1,0,0,0,0), T(4,0,1,0,0), T(4,1,1,0,0), T(4,1,1,0,0), T(4,1,2,0,0),
               T(2,0,0,1,1), T(0,0,0,0,0)};
`else
        ex = '{T(1,0,0,0,0), T(4,0,1,0,0), T(4,1,1,0,0), T(3,0,0,1,0), T(3,0,0,0,0),
               T(0,0,0,0,0), T(0,0,0,0,0)};
`endif
        for (int i = 0; i < 7; i++) begin
            step(st[i]);
            tests++;
            if ((cur() & mk(ex[i])) !== (ex[i] & mk(ex[i]))) begin
                fails++; $display("FAIL whitespace[%0d] got=%h exp=%h", i, cur(), ex[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] st [8];
        logic [10:0] ex [8];
        step(S(NUL)); step(S(DOL)); step(S(CA));
        #2 rst = 1'b0;
        #1;
        tests++;
        if (cur() !== 11'h000) begin
            fails++; $display("FAIL reset_mid got=%h exp=000", cur());
        end
        @(posedge clk);
        #1 rst = 1'b1;
        model_clear();
        st = '{IDL, IDL, IDL, S(NUL), S(DOL), S(CA), S(NUL), IDL};
        ex = '{T(0,0,0,0,0), T(0,0,0,0,0), T(0,0,0,0,0), T(1,0,0,0,0), T(3,0,0,1,0),
               T(3,0,0,0,0), T(0,0,0,0,0), T(0,0,0,0,0)};
        for (int i = 0; i < 8; i++) begin
            step(st[i]);
            tests++;
            if ((cur() & mk(ex[i])) !== (ex[i] & mk(ex[i]))) begin
                fails++; $display("FAIL reset_mid_after[%0d] got=%h exp=%h", i, cur(), ex[i]);
            end
        end
    endtask

    task automatic test_random_back_to_back();
        bit          exp_q [$];
        logic [15:0] stim [$];
        int n_str = 0;
        int n_done = 0;
        int len;
        bit e;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N_TOK; i++)
                cfg(i, rmask(), $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2) == 0);
            for (int s = 0; s < 25; s++) begin
                len = $urandom_range(0, 7);
                sq.delete();
                for (int k = 0; k < len; k++) sq.push_back(rchar());
                exp_q.push_back(model_accept());
                n_str++;
                stim.delete();
                if ($urandom_range(0, 2) == 0) stim.push_back(IDL);
                stim.push_back(S(NUL));
                for (int k = 0; k < len; k++) begin
                    if ($urandom_range(0, 4) == 0) stim.push_back(IDL);
                    stim.push_back(S(sq[k]));
                end
                stim.push_back(S(NUL));
                stim.push_back(($urandom_range(0, 1) == 1) ? S(rchar()) : IDL);
                for (int i = 0; i < stim.size(); i++) begin
                    step(stim[i]);
                    if (bus.done === 1'b1) begin
                        n_done++;
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++; $display("FAIL random_extra_done table=%0d str=%0d", r, s);
                        end else begin
                            e = exp_q.pop_front();
                            if (bus.match !== e) begin
                                fails++;
                                $display("FAIL random_match table=%0d str=%0d got=%0b exp=%0b", r, s, bus.match, e);
                            end
                        end
                    end
                end
            end
        end
        tests++;
        if (n_done != n_str || exp_q.size() != 0) begin
            fails++; $display("FAIL random_done_count got=%0d exp=%0d", n_done, n_str);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus.valid = 1'b0; bus.verify_error = 1'b0; bus.cls = '0;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_mask = '0;
        bus.cfg_min = '0; bus.cfg_max = '0; bus.cfg_last = 1'b0;
        model_clear();
        test_reset();
        program_std();
        test_basic();
        test_too_long();
        test_empty();
        test_verify_error();
        test_cfg_ignored();
        test_cfg_on_start();
        test_ws();
        test_reset_mid();
        test_random_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
